// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;
    localparam int unsigned PC_INC         = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding {pc, word} pairs between the cache and decode.
// Flush empties it in a single edge and overrides a same-cycle push or pop.
module fetch_fifo #(
    parameter int PC_BITS = 32,
    parameter int BITS    = 32,
    parameter int DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [PC_BITS-1:0]     push_pc,
    input  logic [BITS-1:0]        push_word,
    output logic [PC_BITS-1:0]     head_pc,
    output logic [BITS-1:0]        head_word,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_BITS-1:0] pc_mem   [DEPTH];
    logic [BITS-1:0]    word_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_pc   = pc_mem[rd_ptr];
    assign head_word = word_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]   <= push_pc;
            word_mem[wr_ptr] <= push_word;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// PC generation and instruction fetch: one outstanding cache request, a small
// prefetch buffer toward decode, and redirect/halt handling from decode controls.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 BITS       = 32,
    parameter int                 PC_BITS    = 32,
    parameter int                 JMP_LEFT   = 25,
    parameter int                 IMM_LEFT   = 16,
    parameter int                 FIFO_DEPTH = 2,
    parameter logic [PC_BITS-1:0] RESET_PC   = PC_BITS'(DEF_RESET_PC),
    parameter logic [PC_BITS-1:0] EXC_VECTOR = PC_BITS'(DEF_EXC_VECTOR)
) (
    input  logic                clk,
    input  logic                rst_,
    output logic                ic_req,
    output logic [PC_BITS-1:0]  ic_addr,
    input  logic                ic_ack,
    input  logic [BITS-1:0]     ic_data,
    output logic [BITS-1:0]     mem_data,
    output logic                load_instr,
    output logic [PC_BITS-1:0]  dec_pc,
    output logic [PC_BITS-1:0]  link_pc,
    output logic [PC_BITS-1:0]  epc,
    input  logic                jmp,
    input  logic                jal,
    input  logic                jreg,
    input  logic                breq,
    input  logic                brne,
    input  logic                equal,
    input  logic                not_equal,
    input  logic                halt,
    input  logic                exception,
    input  logic [JMP_LEFT:0]   addr,
    input  logic [IMM_LEFT-1:0] imm,
    input  logic [BITS-1:0]     jreg_data,
    input  logic                stall_pipe
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PC_BITS-1:0] INC = PC_BITS'(PC_INC);

    fetch_state_e       state, state_n;
    logic               req_n;
    logic [PC_BITS-1:0] addr_n;
    logic [PC_BITS-1:0] fetch_pc, fetch_pc_n;
    logic [PC_BITS-1:0] dec_pc_n;
    logic [PC_BITS-1:0] epc_n;

    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, count_n;
    logic [PC_BITS-1:0] head_pc;
    logic [BITS-1:0]    head_word;

    logic               ack_ok, pop_req, br_taken;
    logic               take_exc, take_halt, take_jump;
    logic [PC_BITS-1:0] br_off, target;

    fetch_fifo #(
        .PC_BITS (PC_BITS),
        .BITS    (BITS),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .push_pc   (ic_addr),
        .push_word (ic_data),
        .head_pc   (head_pc),
        .head_word (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign load_instr = !fifo_empty;
    assign mem_data   = fifo_empty ? '0 : head_word;
    assign link_pc    = dec_pc + INC;
    assign ack_ok     = ic_req && ic_ack;
    assign pop_req    = load_instr && !stall_pipe;

    // Redirect target and priority: exception > halt > jreg > jmp/jal > branch.
    always_comb begin
        br_off    = {{(PC_BITS-IMM_LEFT-2){imm[IMM_LEFT-1]}}, imm, 2'b00};
        br_taken  = (breq && equal) || (brne && not_equal);
        take_exc  = !stall_pipe && exception;
        take_halt = !stall_pipe && !exception && halt;
        take_jump = !stall_pipe && !exception && !halt && (jreg || jmp || jal || br_taken);
        if (exception)
            target = EXC_VECTOR;
        else if (jreg)
            target = jreg_data[PC_BITS-1:0] & ~PC_BITS'(3);
        else if (jmp || jal)
            target = {link_pc[PC_BITS-1:JMP_LEFT+3], addr, 2'b00};
        else
            target = link_pc + br_off;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n    = state;
        req_n      = ic_req && !ic_ack;
        addr_n     = ic_addr;
        fetch_pc_n = fetch_pc;
        dec_pc_n   = dec_pc;
        epc_n      = epc;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state)
            ST_RUN, ST_DRAIN: begin
                if (take_exc || take_jump) begin
                    fifo_flush = 1'b1;
                    fetch_pc_n = target;
                    if (take_exc) epc_n = dec_pc;
                    state_n = req_n ? ST_DRAIN : ST_RUN;
                end else if (take_halt) begin
                    fifo_flush = 1'b1;
                    state_n    = ST_HALTED;
                end else if (state == ST_DRAIN) begin
                    if (!req_n) state_n = ST_RUN;
                end else begin
                    fifo_pop  = pop_req;
                    fifo_push = ack_ok && (!fifo_full || pop_req);
                    if (pop_req) dec_pc_n = head_pc;
                end
            end
            ST_HALTED: fifo_flush = 1'b1;
            default:   state_n = ST_HALTED;
        endcase

        // Issue only if the word would still fit after this edge's push/pop.
        count_n = fifo_flush ? '0 : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        if (state_n == ST_RUN && !req_n && count_n < CNT_W'(FIFO_DEPTH)) begin
            req_n      = 1'b1;
            addr_n     = fetch_pc_n;
            fetch_pc_n = fetch_pc_n + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state    <= ST_RUN;
            ic_req   <= 1'b0;
            ic_addr  <= RESET_PC;
            fetch_pc <= RESET_PC;
            dec_pc   <= RESET_PC;
            epc      <= '0;
        end else begin
            state    <= state_n;
            ic_req   <= req_n;
            ic_addr  <= addr_n;
            fetch_pc <= fetch_pc_n;
            dec_pc   <= dec_pc_n;
            epc      <= epc_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural cache of programmable ack latency.
module tb_instr_fetch;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ic_req, ic_ack;
    logic [31:0] ic_addr, ic_data;
    logic [31:0] mem_data, dec_pc, link_pc, epc;
    logic        load_instr;
    logic        jmp, jal, jreg, breq, brne, equal, not_equal, halt, exception;
    logic [25:0] addr;
    logic [15:0] imm;
    logic [31:0] jreg_data;
    logic        stall_pipe;

    int errors = 0;
    int checks = 0;

    logic ack_en, ack_force;
    int   ack_lat;
    int   wait_cnt;

    instr_fetch dut (
        .clk        (clk),
        .rst_       (rst_),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_ack     (ic_ack),
        .ic_data    (ic_data),
        .mem_data   (mem_data),
        .load_instr (load_instr),
        .dec_pc     (dec_pc),
        .link_pc    (link_pc),
        .epc        (epc),
        .jmp        (jmp),
        .jal        (jal),
        .jreg       (jreg),
        .breq       (breq),
        .brne       (brne),
        .equal      (equal),
        .not_equal  (not_equal),
        .halt       (halt),
        .exception  (exception),
        .addr       (addr),
        .imm        (imm),
        .jreg_data  (jreg_data),
        .stall_pipe (stall_pipe)
    );

    always #5 clk = ~clk;

    // Cache model: acks once a request has waited ack_lat cycles; data is address-derived.
    assign ic_ack  = ack_force || (ack_en && ic_req && (wait_cnt >= ack_lat));
    assign ic_data = ic_addr ^ SALT;

    always @(posedge clk) begin
        if (!rst_ || !ic_req || ic_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        jmp = 0; jal = 0; jreg = 0; breq = 0; brne = 0; equal = 0; not_equal = 0;
        halt = 0; exception = 0; addr = '0; imm = '0; jreg_data = '0;
    endtask

    // Leaves rst_ asserted after two reset edges.
    task automatic do_reset();
        rst_ = 0; stall_pipe = 0; ack_force = 0; ack_en = 1; ack_lat = 0;
        clear_ctrl();
        tick();
        tick();
    endtask

    // Release reset and let an ack-every-cycle stream run for n edges.
    task automatic stream_to(input int n);
        do_reset();
        rst_ = 1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL reset_ic_req: got %h want 0", ic_req); end
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL reset_ic_addr: got %h want 0", ic_addr); end
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL reset_load_instr: got %h want 0", load_instr); end
        checks++; if (mem_data !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h want 0", mem_data); end
        checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
        checks++; if (link_pc !== 32'h4) begin errors++; $display("FAIL reset_link_pc: got %h want 4", link_pc); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", epc); end
        rst_ = 1;
        tick();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL first_req: got %h want 1", ic_req); end
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", ic_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] e_addr, e_data, e_dec;
        stream_to(1);
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL stream_addr0: got %h want 0", ic_addr); end
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL stream_load0: got %h want 0", load_instr); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            e_addr = 32'(4 * k);
            e_data = 32'(4 * (k - 1)) ^ SALT;
            e_dec  = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
            checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d: got %h want 1", k, ic_req); end
            checks++; if (ic_addr !== e_addr) begin errors++; $display("FAIL stream_addr k=%0d: got %h want %h", k, ic_addr, e_addr); end
            checks++; if (load_instr !== 1'b1) begin errors++; $display("FAIL stream_load k=%0d: got %h want 1", k, load_instr); end
            checks++; if (mem_data !== e_data) begin errors++; $display("FAIL stream_data k=%0d: got %h want %h", k, mem_data, e_data); end
            checks++; if (dec_pc !== e_dec) begin errors++; $display("FAIL stream_dec_pc k=%0d: got %h want %h", k, dec_pc, e_dec); end
            checks++; if (link_pc !== e_dec + 32'h4) begin errors++; $display("FAIL stream_link k=%0d: got %h want %h", k, link_pc, e_dec + 32'h4); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e_addr, e_data, e_dec;
        stream_to(2);
        stall_pipe = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL stall_req i=%0d: got %h want 0", i, ic_req); end
            checks++; if (load_instr !== 1'b1) begin errors++; $display("FAIL stall_load i=%0d: got %h want 1", i, load_instr); end
            checks++; if (mem_data !== SALT) begin errors++; $display("FAIL stall_data i=%0d: got %h want %h", i, mem_data, SALT); end
            checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL stall_dec_pc i=%0d: got %h want 0", i, dec_pc); end
        end
        stall_pipe = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e_addr = 32'(4 * (i + 2));
            e_data = 32'(4 * (i + 1)) ^ SALT;
            e_dec  = 32'(4 * i);
            checks++; if (ic_addr !== e_addr) begin errors++; $display("FAIL unstall_addr i=%0d: got %h want %h", i, ic_addr, e_addr); end
            checks++; if (mem_data !== e_data) begin errors++; $display("FAIL unstall_data i=%0d: got %h want %h", i, mem_data, e_data); end
            checks++; if (dec_pc !== e_dec) begin errors++; $display("FAIL unstall_dec_pc i=%0d: got %h want %h", i, dec_pc, e_dec); end
        end
    endtask

    task automatic test_jump_drain();
        stream_to(7);
        ack_lat = 2;
        jmp = 1; addr = 26'h40;
        tick();
        clear_ctrl();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL drain_req_held: got %h want 1", ic_req); end
        checks++; if (ic_addr !== 32'h18) begin errors++; $display("FAIL drain_addr_held: got %h want 18", ic_addr); end
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL drain_flush: got %h want 0", load_instr); end
        checks++; if (dec_pc !== 32'h10) begin errors++; $display("FAIL drain_dec_pc: got %h want 10", dec_pc); end
        tick();
        checks++; if (ic_addr !== 32'h18) begin errors++; $display("FAIL drain_addr_held2: got %h want 18", ic_addr); end
        tick();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL jmp_req: got %h want 1", ic_req); end
        checks++; if (ic_addr !== 32'h100) begin errors++; $display("FAIL jmp_addr: got %h want 100", ic_addr); end
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL stale_discard: got %h want 0", load_instr); end
        tick();
        tick();
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL jmp_wait_empty: got %h want 0", load_instr); end
        tick();
        checks++; if (load_instr !== 1'b1) begin errors++; $display("FAIL jmp_load: got %h want 1", load_instr); end
        checks++; if (mem_data !== (32'h100 ^ SALT)) begin errors++; $display("FAIL jmp_data: got %h want %h", mem_data, 32'h100 ^ SALT); end
        checks++; if (ic_addr !== 32'h104) begin errors++; $display("FAIL jmp_next_addr: got %h want 104", ic_addr); end
    endtask

    // Decode sits at 0x20 with the request for 0x28 acked in the branch cycle.
    task automatic run_branch(input string name, input logic br, input logic bn, input logic eq,
                              input logic ne, input logic [15:0] im, input bit taken,
                              input logic [31:0] e_addr);
        logic [31:0] e_dec;
        stream_to(11);
        breq = br; brne = bn; equal = eq; not_equal = ne; imm = im;
        tick();
        clear_ctrl();
        e_dec = taken ? 32'h20 : 32'h24;
        checks++; if (ic_addr !== e_addr) begin errors++; $display("FAIL %s_addr: got %h want %h", name, ic_addr, e_addr); end
        checks++; if (dec_pc !== e_dec) begin errors++; $display("FAIL %s_dec_pc: got %h want %h", name, dec_pc, e_dec); end
        checks++; if (load_instr !== !taken) begin errors++; $display("FAIL %s_load: got %h want %h", name, load_instr, !taken); end
        if (taken) begin
            tick();
            checks++; if (mem_data !== (e_addr ^ SALT)) begin errors++; $display("FAIL %s_data: got %h want %h", name, mem_data, e_addr ^ SALT); end
        end else begin
            checks++; if (mem_data !== (32'h28 ^ SALT)) begin errors++; $display("FAIL %s_data: got %h want %h", name, mem_data, 32'h28 ^ SALT); end
        end
    endtask

    task automatic test_branch();
        run_branch("beq_taken",     1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFC, 1'b1, 32'h14);
        run_branch("beq_not_taken", 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 1'b0, 32'h2C);
        run_branch("bne_taken",     1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 32'h2C);
    endtask

    task automatic test_exception();
        stream_to(15);
        stall_pipe = 1; exception = 1; jreg = 1; jreg_data = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL exc_stall_req i=%0d: got %h want 0", i, ic_req); end
            checks++; if (load_instr !== 1'b1) begin errors++; $display("FAIL exc_stall_load i=%0d: got %h want 1", i, load_instr); end
            checks++; if (dec_pc !== 32'h30) begin errors++; $display("FAIL exc_stall_dec_pc i=%0d: got %h want 30", i, dec_pc); end
            checks++; if (epc !== 32'h0) begin errors++; $display("FAIL exc_stall_epc i=%0d: got %h want 0", i, epc); end
        end
        stall_pipe = 0;
        tick();
        clear_ctrl();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL exc_req: got %h want 1", ic_req); end
        checks++; if (ic_addr !== 32'h180) begin errors++; $display("FAIL exc_addr: got %h want 180", ic_addr); end
        checks++; if (epc !== 32'h30) begin errors++; $display("FAIL exc_epc: got %h want 30", epc); end
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL exc_flush: got %h want 0", load_instr); end
        tick();
        checks++; if (mem_data !== (32'h180 ^ SALT)) begin errors++; $display("FAIL exc_data: got %h want %h", mem_data, 32'h180 ^ SALT); end
        checks++; if (ic_addr !== 32'h184) begin errors++; $display("FAIL exc_next_addr: got %h want 184", ic_addr); end
    endtask

    task automatic test_halt_and_reset();
        stream_to(5);
        ack_lat = 2;
        halt = 1;
        tick();
        clear_ctrl();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL halt_req_held: got %h want 1", ic_req); end
        checks++; if (ic_addr !== 32'h10) begin errors++; $display("FAIL halt_addr_held: got %h want 10", ic_addr); end
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL halt_flush: got %h want 0", load_instr); end
        checks++; if (dec_pc !== 32'h8) begin errors++; $display("FAIL halt_dec_pc: got %h want 8", dec_pc); end
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL halted_req i=%0d: got %h want 0", i, ic_req); end
            checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL halted_load i=%0d: got %h want 0", i, load_instr); end
        end

        // Reset while a slow request is in flight, then a stray ack with no request.
        do_reset();
        ack_lat = 5;
        rst_ = 1;
        tick();
        tick();
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL midreq_req: got %h want 1", ic_req); end
        rst_ = 0;
        tick();
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL midreq_reset_req: got %h want 0", ic_req); end
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL midreq_reset_addr: got %h want 0", ic_addr); end
        rst_ = 1; ack_force = 1;
        tick();
        ack_force = 0; ack_lat = 0;
        checks++; if (load_instr !== 1'b0) begin errors++; $display("FAIL stray_ack: got %h want 0", load_instr); end
        checks++; if (ic_req !== 1'b1) begin errors++; $display("FAIL restart_req: got %h want 1", ic_req); end
        checks++; if (ic_addr !== 32'h0) begin errors++; $display("FAIL restart_addr: got %h want 0", ic_addr); end
        tick();
        checks++; if (load_instr !== 1'b1) begin errors++; $display("FAIL restart_load: got %h want 1", load_instr); end
        checks++; if (mem_data !== SALT) begin errors++; $display("FAIL restart_data: got %h want %h", mem_data, SALT); end
        checks++; if (ic_addr !== 32'h4) begin errors++; $display("FAIL restart_next_addr: got %h want 4", ic_addr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ = 0; stall_pipe = 0; ack_en = 0; ack_force = 0; ack_lat = 0;
        clear_ctrl();
        test_reset();
        test_stream();
        test_stall();
        test_jump_drain();
        test_branch();
        test_exception();
        test_halt_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
